mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning memory access latency in cycles (legal range 1..15).
REQ-002 SHALL have port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port if_req_i  input  1  instruction fetch request, from PC/IF stage.
REQ-005 SHALL have port if_addr_i  input  32  fetch byte address.
REQ-006 SHALL have ports dm_read_i and dm_write_i  input  1 each  MEM stage load/store request.
REQ-007 SHALL have ports dm_addr_i and dm_wdata_i  input  32 each  data address and store data.
REQ-008 SHALL have port mem_req_o  output  1  unified single-port memory access strobe.
REQ-009 SHALL have port mem_we_o  output  1  memory write enable.
REQ-010 SHALL have ports mem_addr_o and mem_wdata_o  output  32 each  memory address and write data.
REQ-011 SHALL have port mem_rdata_i  input  32  memory read data, valid in the last access cycle.
REQ-012 SHALL have ports if_ack_o and dm_ack_o  output  1 each  one-cycle completion pulses.
REQ-013 SHALL have ports if_rdata_o and dm_rdata_o  output  32 each  held read data.
REQ-014 SHALL have ports stall_if_o and stall_mem_o  output  1 each  pipeline freeze for IF/ID and MEM stage.

Function
REQ-015 SHALL implement FSM states IDLE, SERVE_DM, SERVE_IF.
REQ-016 SHALL, in IDLE with a DM request (dm_read_i or dm_write_i) pending, enter SERVE_DM next cycle; else with if_req_i, enter SERVE_IF; else remain in IDLE.
REQ-017 SHALL latch address, write data and direction at grant and hold them stable on mem_* for the whole service, independent of later input changes.
REQ-018 SHALL assert mem_req_o for exactly MEM_LAT consecutive cycles per service, using a down-counter loaded with MEM_LAT-1 at grant.
REQ-019 SHALL, in the cycle the counter is zero, pulse the matching ack for one cycle and capture mem_rdata_i into the matching rdata register (rdata register unchanged on stores).
REQ-020 SHALL, on the ack cycle, transition directly to the next grant without an idle bubble if any request is pending, else to IDLE.
REQ-021 SHALL give DM priority, except that after a completed DM service with if_req_i pending, IF SHALL be granted next (alternation; neither requester starves).
REQ-022 SHALL treat dm_read_i and dm_write_i both high as a store.
REQ-023 SHALL complete and ack a granted transaction even if its request drops mid-service.
REQ-024 SHALL drive stall_if_o = if_req_i and not if_ack_o; stall_mem_o = DM request and not dm_ack_o (combinational).
REQ-025 SHALL drive mem_we_o only during SERVE_DM for a store; zero otherwise.

Reset
REQ-026 SHALL, on rst_i high, immediately enter IDLE, clear the counter, and force mem_req_o, mem_we_o, both acks to 0 and mem_addr_o, mem_wdata_o, both rdata outputs to 0.
REQ-027 SHALL abort an in-flight service on reset with no ack issued; the alternation flag SHALL reset to "DM preferred".

Configuration
REQ-028 SHALL, when macro MEM_ARB_PERF_CNT_EN is defined, add outputs if_wait_cnt_o and dm_wait_cnt_o (32 bits each) counting cycles with stall_if_o resp. stall_mem_o high, saturating at 0xFFFFFFFF, cleared by reset.
REQ-029 SHALL, without MEM_ARB_PERF_CNT_EN, omit those ports and counters entirely with identical arbitration behaviour.

Verification (MEM_LAT=2)
REQ-030 SHALL verify: if_req_i=1, addr 0x10, memory returns 0xDEADBEEF -> mem_req_o high cycles 1-2, if_ack_o pulse cycle 2, if_rdata_o=0xDEADBEEF, stall_if_o low in cycle 2.
REQ-031 SHALL verify: if_req_i and dm_read_i rise together -> DM served first (ack cycle 2), IF served cycles 3-4 with no bubble.
REQ-032 SHALL verify: dm_write_i held 3 transactions with if_req_i held -> grant order DM, IF, DM, IF, DM; mem_we_o high only in DM windows.
REQ-033 SHALL verify: rst_i asserted in cycle 1 of a DM store -> mem_req_o, mem_we_o drop in the same cycle, no dm_ack_o, FSM IDLE after release.
REQ-034 SHALL verify: request dropped after grant cycle -> ack still pulses in cycle 2; with MEM_ARB_PERF_CNT_EN, 10-cycle continuous fetch stream -> if_wait_cnt_o=5.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/memory bus bundle for mem_port_arbiter; the arbiter takes the slave modport.
// Wait-counter signals exist only when MEM_ARB_PERF_CNT_EN is defined.
interface mem_port_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        dm_read_i;
    logic        dm_write_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        if_ack_o;
    logic        dm_ack_o;
    logic [31:0] if_rdata_o;
    logic [31:0] dm_rdata_o;
    logic        stall_if_o;
    logic        stall_mem_o;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] if_wait_cnt_o;
    logic [31:0] dm_wait_cnt_o;
`endif

    modport slave (
        input  if_req_i, if_addr_i, dm_read_i, dm_write_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
`ifdef MEM_ARB_PERF_CNT_EN
        output if_wait_cnt_o, dm_wait_cnt_o,
`endif
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_ack_o, dm_ack_o,
        output if_rdata_o, dm_rdata_o, stall_if_o, stall_mem_o
    );

    modport master (
        output if_req_i, if_addr_i, dm_read_i, dm_write_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
`ifdef MEM_ARB_PERF_CNT_EN
        input  if_wait_cnt_o, dm_wait_cnt_o,
`endif
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_ack_o, dm_ack_o,
        input  if_rdata_o, dm_rdata_o, stall_if_o, stall_mem_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port memory, DM first with
// IF/DM alternation. Define MEM_ARB_PERF_CNT_EN to add saturating stall-cycle counters.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input logic             clk_i,
    input logic             rst_i,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StServeDm, StServeIf} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        prefer_if_q, prefer_if_d;
    logic [31:0] if_rdata_q, dm_rdata_q;

    logic dm_pend, last_cycle, if_ack, dm_ack, decide, grant_dm, grant_if;

    assign dm_pend    = bus.dm_read_i | bus.dm_write_i;
    assign last_cycle = (state_q != StIdle) && (cnt_q == 4'd0);
    assign if_ack     = (state_q == StServeIf) && last_cycle;
    assign dm_ack     = (state_q == StServeDm) && last_cycle;
    assign decide     = (state_q == StIdle) || last_cycle;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        prefer_if_d = prefer_if_q;
        grant_dm    = 1'b0;
        grant_if    = 1'b0;

        // prefer_if_q only bites on a DM ack cycle; from idle DM always wins.
        if (decide) begin
            if (dm_pend && !(last_cycle && prefer_if_q && bus.if_req_i)) begin
                grant_dm = 1'b1;
            end else if (bus.if_req_i) begin
                grant_if = 1'b1;
            end
        end

        if (grant_dm) begin
            state_d     = StServeDm;
            cnt_d       = 4'(MEM_LAT - 1);
            addr_d      = bus.dm_addr_i;
            wdata_d     = bus.dm_wdata_i;
            we_d        = bus.dm_write_i;
            prefer_if_d = 1'b1;
        end else if (grant_if) begin
            state_d     = StServeIf;
            cnt_d       = 4'(MEM_LAT - 1);
            addr_d      = bus.if_addr_i;
            wdata_d     = 32'h0;
            we_d        = 1'b0;
            prefer_if_d = 1'b0;
        end else if (decide) begin
            state_d     = StIdle;
            prefer_if_d = 1'b0;
        end else begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            we_q        <= 1'b0;
            prefer_if_q <= 1'b0;
            if_rdata_q  <= 32'h0;
            dm_rdata_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            prefer_if_q <= prefer_if_d;
            if (if_ack) begin
                if_rdata_q <= bus.mem_rdata_i;
            end
            if (dm_ack && !we_q) begin
                dm_rdata_q <= bus.mem_rdata_i;
            end
        end
    end

    assign bus.mem_req_o   = (state_q != StIdle);
    assign bus.mem_we_o    = (state_q == StServeDm) && we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.if_ack_o    = if_ack;
    assign bus.dm_ack_o    = dm_ack;
    // Read data is forwarded in the ack cycle so it is valid together with the ack pulse.
    assign bus.if_rdata_o  = if_ack ? bus.mem_rdata_i : if_rdata_q;
    assign bus.dm_rdata_o  = (dm_ack && !we_q) ? bus.mem_rdata_i : dm_rdata_q;
    assign bus.stall_if_o  = bus.if_req_i & ~if_ack;
    assign bus.stall_mem_o = dm_pend & ~dm_ack;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] if_wait_q, dm_wait_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_wait_q <= 32'h0;
            dm_wait_q <= 32'h0;
        end else begin
            if (bus.stall_if_o && (if_wait_q != 32'hFFFF_FFFF)) begin
                if_wait_q <= if_wait_q + 32'd1;
            end
            if (bus.stall_mem_o && (dm_wait_q != 32'hFFFF_FFFF)) begin
                dm_wait_q <= dm_wait_q + 32'd1;
            end
        end
    end

    assign bus.if_wait_cnt_o = if_wait_q;
    assign bus.dm_wait_cnt_o = dm_wait_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2): vector table of single transactions plus
// hand-written multi-cycle sequences for priority, alternation, reset abort and wait counters.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MEM_LAT(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dm_rd;
        logic        dm_wr;
        logic        if_rq;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_data;
        logic        exp_we;
        logic        exp_if_ack;
        logic        exp_dm_ack;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_dm_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = 32'h0;
        bus.dm_read_i  = 1'b0;
        bus.dm_write_i = 1'b0;
        bus.dm_addr_i  = 32'h0;
        bus.dm_wdata_i = 32'h0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear_inputs();
        bus.mem_rdata_i = 32'h0;

        //                dm_rd dm_wr if_rq addr           wdata          mem_data
        //                we  ifack dmack if_rdata       dm_rdata
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF,
                    1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0000, 32'h1234_5678,
                    1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'hFFFF_0000,
                    1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0BAD_F00D, 32'h1111_1111,
                    1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0001,
                    1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'hA5A5_A5A5,
                    1'b0, 1'b0, 1'b1, 32'h0000_0001, 32'hA5A5_A5A5};

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we_o), 32'h0);
        chk("rst_acks", {30'h0, bus.if_ack_o, bus.dm_ack_o}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
        chk("rst_if_rdata", bus.if_rdata_o, 32'h0);
        chk("rst_dm_rdata", bus.dm_rdata_o, 32'h0);
        rst = 1'b0;
        #1;

        // Table: each vector is one isolated transaction, request dropped right after grant.
        for (int i = 0; i < 6; i++) begin
            bus.dm_read_i  = vecs[i].dm_rd;
            bus.dm_write_i = vecs[i].dm_wr;
            bus.if_req_i   = vecs[i].if_rq;
            bus.dm_addr_i  = vecs[i].addr;
            bus.if_addr_i  = vecs[i].addr;
            bus.dm_wdata_i = vecs[i].wdata;
            #1;
            chk($sformatf("v%0d_c0_mem_req", i), 32'(bus.mem_req_o), 32'h0);
            tick();
            clear_inputs();
            bus.dm_addr_i  = 32'hBAD0_0000;
            bus.if_addr_i  = 32'hBAD1_0000;
            bus.dm_wdata_i = 32'hBAD2_0000;
            #1;
            chk($sformatf("v%0d_c1_mem_req", i), 32'(bus.mem_req_o), 32'h1);
            chk($sformatf("v%0d_c1_we", i), 32'(bus.mem_we_o), 32'(vecs[i].exp_we));
            chk($sformatf("v%0d_c1_addr", i), bus.mem_addr_o, vecs[i].addr);
            chk($sformatf("v%0d_c1_wdata", i), bus.mem_wdata_o, vecs[i].wdata);
            chk($sformatf("v%0d_c1_acks", i), {30'h0, bus.if_ack_o, bus.dm_ack_o}, 32'h0);
            tick();
            bus.mem_rdata_i = vecs[i].mem_data;
            #1;
            chk($sformatf("v%0d_c2_mem_req", i), 32'(bus.mem_req_o), 32'h1);
            chk($sformatf("v%0d_c2_addr", i), bus.mem_addr_o, vecs[i].addr);
            chk($sformatf("v%0d_c2_if_ack", i), 32'(bus.if_ack_o), 32'(vecs[i].exp_if_ack));
            chk($sformatf("v%0d_c2_dm_ack", i), 32'(bus.dm_ack_o), 32'(vecs[i].exp_dm_ack));
            chk($sformatf("v%0d_c2_if_rdata", i), bus.if_rdata_o, vecs[i].exp_if_rdata);
            chk($sformatf("v%0d_c2_dm_rdata", i), bus.dm_rdata_o, vecs[i].exp_dm_rdata);
            tick();
            bus.mem_rdata_i = 32'h0;
            #1;
            chk($sformatf("v%0d_c3_mem_req", i), 32'(bus.mem_req_o), 32'h0);
            chk($sformatf("v%0d_c3_acks", i), {30'h0, bus.if_ack_o, bus.dm_ack_o}, 32'h0);
            chk($sformatf("v%0d_c3_if_rdata", i), bus.if_rdata_o, vecs[i].exp_if_rdata);
            chk($sformatf("v%0d_c3_dm_rdata", i), bus.dm_rdata_o, vecs[i].exp_dm_rdata);
        end

        // Fetch with request held: stall drops exactly in the ack cycle.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_0010;
        #1;
        chk("a_c0_stall_if", 32'(bus.stall_if_o), 32'h1);
        tick();
        chk("a_c1_stall_if", 32'(bus.stall_if_o), 32'h1);
        chk("a_c1_mem_req", 32'(bus.mem_req_o), 32'h1);
        tick();
        bus.mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("a_c2_if_ack", 32'(bus.if_ack_o), 32'h1);
        chk("a_c2_stall_if", 32'(bus.stall_if_o), 32'h0);
        chk("a_c2_if_rdata", bus.if_rdata_o, 32'hDEAD_BEEF);
        bus.if_req_i = 1'b0;
        #1;
        tick();
        chk("a_c3_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("a_c3_if_rdata", bus.if_rdata_o, 32'hDEAD_BEEF);

        // Simultaneous DM read and fetch: DM first, IF follows with no bubble.
        bus.dm_read_i = 1'b1;
        bus.dm_addr_i = 32'h0000_0400;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_0500;
        tick();
        chk("b_c1_addr", bus.mem_addr_o, 32'h0000_0400);
        chk("b_c1_we", 32'(bus.mem_we_o), 32'h0);
        tick();
        bus.mem_rdata_i = 32'h600D_CAFE;
        #1;
        chk("b_c2_dm_ack", 32'(bus.dm_ack_o), 32'h1);
        chk("b_c2_if_ack", 32'(bus.if_ack_o), 32'h0);
        chk("b_c2_dm_rdata", bus.dm_rdata_o, 32'h600D_CAFE);
        chk("b_c2_stall_mem", 32'(bus.stall_mem_o), 32'h0);
        bus.dm_read_i = 1'b0;
        #1;
        tick();
        chk("b_c3_mem_req", 32'(bus.mem_req_o), 32'h1);
        chk("b_c3_addr", bus.mem_addr_o, 32'h0000_0500);
        chk("b_c3_if_ack", 32'(bus.if_ack_o), 32'h0);
        tick();
        bus.mem_rdata_i = 32'h0000_BEEF;
        #1;
        chk("b_c4_if_ack", 32'(bus.if_ack_o), 32'h1);
        chk("b_c4_if_rdata", bus.if_rdata_o, 32'h0000_BEEF);
        bus.if_req_i = 1'b0;
        #1;
        tick();
        chk("b_c5_mem_req", 32'(bus.mem_req_o), 32'h0);

        // Both held: grants alternate DM, IF, DM, IF, DM in 2-cycle windows.
        bus.dm_write_i = 1'b1;
        bus.dm_addr_i  = 32'h0000_1000;
        bus.dm_wdata_i = 32'h0000_0055;
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h0000_2000;
        #1;
        chk("c_c0_stalls", {30'h0, bus.stall_if_o, bus.stall_mem_o}, 32'h3);
        for (int c = 1; c <= 10; c++) begin
            logic is_dm;
            logic ack_now;
            tick();
            is_dm   = (((c - 1) / 2) % 2) == 0;
            ack_now = (c % 2) == 0;
            chk($sformatf("c_c%0d_mem_req", c), 32'(bus.mem_req_o), 32'h1);
            chk($sformatf("c_c%0d_we", c), 32'(bus.mem_we_o), 32'(is_dm));
            chk($sformatf("c_c%0d_addr", c), bus.mem_addr_o,
                is_dm ? 32'h0000_1000 : 32'h0000_2000);
            chk($sformatf("c_c%0d_dm_ack", c), 32'(bus.dm_ack_o), 32'(ack_now && is_dm));
            chk($sformatf("c_c%0d_if_ack", c), 32'(bus.if_ack_o), 32'(ack_now && !is_dm));
        end
        clear_inputs();
        #1;
        tick();
        chk("c_c11_mem_req", 32'(bus.mem_req_o), 32'h0);

        // Reset in the first cycle of a store aborts it without an ack.
        bus.dm_write_i = 1'b1;
        bus.dm_addr_i  = 32'h0000_3000;
        bus.dm_wdata_i = 32'h0000_0077;
        tick();
        chk("d_c1_we", 32'(bus.mem_we_o), 32'h1);
        rst = 1'b1;
        #1;
        chk("d_rst_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("d_rst_mem_we", 32'(bus.mem_we_o), 32'h0);
        chk("d_rst_dm_ack", 32'(bus.dm_ack_o), 32'h0);
        chk("d_rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("d_rst_if_rdata", bus.if_rdata_o, 32'h0);
        bus.dm_write_i = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("d_post_%0d_mem_req", c), 32'(bus.mem_req_o), 32'h0);
            chk($sformatf("d_post_%0d_dm_ack", c), 32'(bus.dm_ack_o), 32'h0);
        end

`ifdef MEM_ARB_PERF_CNT_EN
        // Continuous fetch stream; the value seen in cycle 9 covers cycles 0..8.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_0040;
        for (int c = 1; c <= 9; c++) begin
            tick();
        end
        chk("e_if_wait_cnt", bus.if_wait_cnt_o, 32'd5);
        chk("e_dm_wait_cnt", bus.dm_wait_cnt_o, 32'd0);
        bus.if_req_i = 1'b0;
        tick();
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
